// File: rtl/symcnt_pkg.sv
// Shared types and constants for the symbol counter controller.
// Count width and saturation value are fixed here so every lane agrees on them.
package symcnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2
    } state_t;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage : symcnt_pkg

// File: rtl/symbol_count_ctrl_single_count.sv
// One compare/increment lane: returns the lane count, bumped by one when the
// lane is enabled and the incoming symbol equals this lane's alphabet entry.
module SingleCount
    import symcnt_pkg::*;
#(
    parameter int S_WIDTH = 8
) (
    input  logic               i_mode,
    input  logic [S_WIDTH-1:0] i_symbol,
    input  logic [S_WIDTH-1:0] i_alpha,
    input  logic [CNT_W-1:0]   i_count,
    output logic [CNT_W-1:0]   o_count
);

    logic w_match;

    assign w_match = (i_symbol == i_alpha);
    assign o_count = (i_mode && w_match) ? (i_count + CNT_W'(1)) : i_count;

endmodule : SingleCount

// File: rtl/symbol_count_ctrl.sv
// Symbol counter: loads an alphabet, counts matching text symbols per lane,
// then streams out one (symbol, count) pair per alphabet entry.
//
//   state | meaning
//   IDLE  | alphabet load allowed; waits for start with a complete alphabet
//   COUNT | accepts text symbols, one per cycle, until s_last
//   DUMP  | presents alpha[rptr]/count[rptr] until the last entry is taken
module symbol_count_ctrl
    import symcnt_pkg::*;
#(
    parameter int S_WIDTH   = 8,
    parameter int N_SYMBOLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alpha_valid,
    input  logic [S_WIDTH-1:0] alpha_data,
    output logic               alpha_ready,
    output logic               alpha_loaded,
    input  logic               start,
    input  logic               s_valid,
    input  logic [S_WIDTH-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               r_valid,
    output logic [S_WIDTH-1:0] r_symbol,
    output logic [CNT_W-1:0]   r_count,
    output logic               r_last,
    input  logic               r_ready,
    output logic               busy
);

    localparam int               IDX_W    = $clog2(N_SYMBOLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYMBOLS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [S_WIDTH-1:0] r_alpha   [N_SYMBOLS];
    logic [CNT_W-1:0]   r_cnt     [N_SYMBOLS];
    logic [CNT_W-1:0]   w_cnt_nxt [N_SYMBOLS];
    logic [N_SYMBOLS-1:0] w_mode;
    logic [IDX_W-1:0]   r_wptr;
    logic [IDX_W-1:0]   r_rptr;
    logic               r_alpha_loaded;

    logic w_alpha_hs;
    logic w_s_hs;
    logic w_r_hs;
    logic w_start_go;

    assign w_alpha_hs   = alpha_valid & alpha_ready;
    assign w_s_hs       = s_valid & s_ready;
    assign w_r_hs       = r_valid & r_ready;
    assign w_start_go   = (r_state == IDLE) & start & r_alpha_loaded;
    assign alpha_loaded = r_alpha_loaded;
    assign busy         = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        alpha_ready = 1'b0;
        s_ready     = 1'b0;
        r_valid     = 1'b0;
        r_symbol    = '0;
        r_count     = '0;
        r_last      = 1'b0;
        case (r_state)
            IDLE: begin
                // Alphabet writes are blocked only on the cycle a start is taken.
                alpha_ready = !(start & r_alpha_loaded);
                if (w_start_go) begin
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    w_state_nxt = DUMP;
                end
            end
            DUMP: begin
                r_valid  = 1'b1;
                r_symbol = r_alpha[r_rptr];
                r_count  = r_cnt[r_rptr];
                r_last   = (r_rptr == LAST_IDX);
                if (r_ready && (r_rptr == LAST_IDX)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_SYMBOLS; gi++) begin : g_lane
        // Saturation is enforced by withholding the enable at CNT_MAX.
        assign w_mode[gi] = w_s_hs & (r_cnt[gi] != CNT_MAX);

        SingleCount #(
            .S_WIDTH (S_WIDTH)
        ) u_single_count (
            .i_mode   (w_mode[gi]),
            .i_symbol (s_data),
            .i_alpha  (r_alpha[gi]),
            .i_count  (r_cnt[gi]),
            .o_count  (w_cnt_nxt[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_alpha_loaded <= 1'b0;
            for (int i = 0; i < N_SYMBOLS; i++) begin
                r_alpha[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            if (w_alpha_hs) begin
                r_alpha[r_wptr] <= alpha_data;
                if (r_wptr == LAST_IDX) begin
                    r_alpha_loaded <= 1'b1;
                    r_wptr         <= '0;
                end else begin
                    // A write into a complete alphabet restarts the load at entry 0.
                    r_alpha_loaded <= 1'b0;
                    r_wptr         <= r_wptr + IDX_W'(1);
                end
            end

            if (w_start_go) begin
                for (int i = 0; i < N_SYMBOLS; i++) begin
                    r_cnt[i] <= '0;
                end
            end else if (r_state == COUNT) begin
                for (int i = 0; i < N_SYMBOLS; i++) begin
                    r_cnt[i] <= w_cnt_nxt[i];
                end
            end

            if (w_s_hs && s_last) begin
                r_rptr <= '0;
            end else if (w_r_hs && (r_rptr != LAST_IDX)) begin
                r_rptr <= r_rptr + IDX_W'(1);
            end
        end
    end

endmodule : symbol_count_ctrl

// File: tb/tb_symbol_count_ctrl.sv
// Randomized bench for symbol_count_ctrl; expected counts come from counting
// occurrences of each alphabet entry in the applied text, capped at 255.
module tb_symbol_count_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       alpha_valid;
    logic [7:0] alpha_data;
    logic       alpha_ready;
    logic       alpha_loaded;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       r_valid;
    logic [7:0] r_symbol;
    logic [7:0] r_count;
    logic       r_last;
    logic       r_ready;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_alpha [N];
    logic [7:0] stream_q [$];

    symbol_count_ctrl #(
        .S_WIDTH   (8),
        .N_SYMBOLS (N)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .alpha_valid  (alpha_valid),
        .alpha_data   (alpha_data),
        .alpha_ready  (alpha_ready),
        .alpha_loaded (alpha_loaded),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .r_valid      (r_valid),
        .r_symbol     (r_symbol),
        .r_count      (r_count),
        .r_last       (r_last),
        .r_ready      (r_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_count(input int lane);
        int c = 0;
        foreach (stream_q[k]) begin
            if (stream_q[k] == m_alpha[lane]) c++;
        end
        return (c > 255) ? 255 : c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_alpha(input logic [7:0] d);
        int t = 0;
        alpha_valid = 1'b1;
        alpha_data  = d;
        while (!alpha_ready && t < 50) begin
            step();
            t++;
        end
        chk("alpha_ready_wait", alpha_ready, 1);
        step();
        alpha_valid = 1'b0;
    endtask

    task automatic load_model();
        for (int i = 0; i < N; i++) write_alpha(m_alpha[i]);
        chk("alpha_loaded_after_load", alpha_loaded, 1);
    endtask

    task automatic pulse_start(input bit exp_go);
        start = 1'b1;
        #1;
        chk("alpha_ready_during_start", alpha_ready, !exp_go);
        step();
        start = 1'b0;
        chk("busy_after_start", busy, exp_go);
        chk("s_ready_after_start", s_ready, exp_go);
    endtask

    task automatic run_stream(input int gap_max, input bit rand_start);
        foreach (stream_q[k]) begin
            int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            int t = 0;
            s_valid = 1'b0;
            repeat (g) step();
            s_valid = 1'b1;
            s_data  = stream_q[k];
            s_last  = (k == stream_q.size() - 1);
            start   = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            while (!s_ready && t < 50) begin
                step();
                t++;
            end
            if (t == 50) chk("s_ready_wait", s_ready, 1);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        chk("r_valid_after_last", r_valid, 1);
    endtask

    task automatic run_dump(input int first_stall);
        for (int i = 0; i < N; i++) begin
            int st = (i == 0) ? first_stall : int'($urandom_range(0, 2));
            r_ready = 1'b0;
            for (int c = 0; c <= st; c++) begin
                chk($sformatf("dump%0d_valid", i), r_valid, 1);
                chk($sformatf("dump%0d_symbol_hold%0d", i, c), r_symbol, m_alpha[i]);
                chk($sformatf("dump%0d_count_hold%0d", i, c), r_count, exp_count(i));
                chk($sformatf("dump%0d_last", i), r_last, (i == N - 1));
                if (c < st) step();
            end
            r_ready = 1'b1;
            step();
            r_ready = 1'b0;
        end
        chk("busy_after_dump", busy, 0);
        chk("r_valid_after_dump", r_valid, 0);
    endtask

    initial begin
        rst         = 1'b1;
        alpha_valid = 1'b0;
        alpha_data  = '0;
        start       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        r_ready     = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_alpha_ready", alpha_ready, 1);
        chk("rst_alpha_loaded", alpha_loaded, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_symbol", r_symbol, 0);
        chk("rst_r_count", r_count, 0);
        chk("rst_r_last", r_last, 0);

        // incomplete alphabet: start must be ignored
        m_alpha = '{8'h41, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 3; i++) write_alpha(m_alpha[i]);
        chk("partial_not_loaded", alpha_loaded, 0);
        pulse_start(1'b0);
        write_alpha(m_alpha[3]);
        chk("fourth_write_loaded", alpha_loaded, 1);
        pulse_start(1'b1);
        stream_q = '{8'h41, 8'h42, 8'h42, 8'h41};
        run_stream(0, 1'b0);
        run_dump(0);
        chk("alphabet_persists", alpha_loaded, 1);

        // saturation
        pulse_start(1'b1);
        stream_q.delete();
        for (int i = 0; i < 300; i++) stream_q.push_back(8'h43);
        run_stream(0, 1'b0);
        run_dump(1);

        // duplicate alphabet entries, reload over a complete alphabet, long stall
        m_alpha = '{8'h41, 8'h41, 8'h42, 8'h43};
        write_alpha(m_alpha[0]);
        chk("reload_clears_loaded", alpha_loaded, 0);
        for (int i = 1; i < N; i++) write_alpha(m_alpha[i]);
        chk("reload_loaded", alpha_loaded, 1);
        pulse_start(1'b1);
        stream_q = '{8'h41};
        run_stream(0, 1'b0);
        run_dump(5);

        // randomized trials
        for (int trial = 0; trial < 25; trial++) begin
            int len = int'($urandom_range(1, 30));
            for (int i = 0; i < N; i++) m_alpha[i] = 8'(8'h41 + $urandom_range(0, 5));
            load_model();
            pulse_start(1'b1);
            stream_q.delete();
            for (int k = 0; k < len; k++) stream_q.push_back(8'(8'h40 + $urandom_range(0, 7)));
            run_stream(2, 1'b1);
            run_dump(int'($urandom_range(0, 3)));
        end

        // reset in the middle of counting
        m_alpha = '{8'h41, 8'h42, 8'h43, 8'h44};
        load_model();
        pulse_start(1'b1);
        s_valid = 1'b1;
        s_data  = 8'h42;
        repeat (3) step();
        s_valid = 1'b0;
        rst     = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_alpha_loaded", alpha_loaded, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_alpha_ready", alpha_ready, 1);
        chk("midrst_r_valid", r_valid, 0);
        rst = 1'b0;
        step();
        pulse_start(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_symbol_count_ctrl
